exp_range_monitor: RTL and testbench
====================================

EXP_RANGE_MONITOR -- requirements
Module: exp_range_monitor

Interface
REQ-001 SHALL have parameter EW, default 9, meaning exponent width including one carry/guard MSB (9 = single, 12 = double).
REQ-002 SHALL have parameter U_LIMIT, default 2^(EW-1)-2, meaning the largest normal biased exponent.
REQ-003 SHALL have parameter L_LIMIT, default 1, meaning the smallest normal biased exponent.
REQ-004 SHALL have parameter CW, default 8, meaning the exception event counter width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning in_exp is valid.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts in_exp this cycle.
REQ-009 SHALL have port in_exp, input, EW bits, meaning the exponent from the rounding phase.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the result registers hold a valid result.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the downstream stage consumes the result.
REQ-012 SHALL have port overflow, output, 1 bit, meaning the held exponent is greater than U_LIMIT.
REQ-013 SHALL have port underflow, output, 1 bit, meaning the held exponent is less than L_LIMIT.
REQ-014 SHALL have port exp_out, output, EW bits, meaning the held exponent.
REQ-015 SHALL have port clr, input, 1 bit, meaning synchronous clear of the sticky flags and the counter.
REQ-016 SHALL have port exc_count, output, CW bits, meaning a saturating count of accepted results with overflow or underflow.
REQ-017 SHALL have ports sticky_ovf and sticky_unf, output, 1 bit each, meaning accumulated flags (present only per REQ-030).

Function
REQ-018 Transfer SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-019 Latency SHALL be 1 cycle: a transfer at edge N makes out_valid, exp_out, overflow and underflow reflect that input after edge N.
REQ-020 overflow SHALL be (in_exp > U_LIMIT) and underflow SHALL be (in_exp < L_LIMIT), both unsigned and evaluated at the transfer, then registered.
REQ-021 While out_valid && !out_ready, exp_out, overflow, underflow and out_valid SHALL hold unchanged, and in_ready SHALL be 0.
REQ-022 When out_ready is 1 and no transfer occurs, out_valid SHALL go to 0 on the next edge; overflow and underflow SHALL be forced to 0 whenever out_valid is 0.
REQ-023 A simultaneous transfer and out_ready SHALL replace the result with no bubble, giving one result per cycle.
REQ-024 exc_count SHALL increment by 1 per transfer with overflow or underflow and SHALL saturate at 2^CW-1 without wrapping.
REQ-025 If clr and a counted transfer occur in the same cycle, exc_count SHALL become 1; clr alone SHALL make it 0.
REQ-026 Boundaries: in_exp == U_LIMIT and in_exp == L_LIMIT SHALL raise no flag; overflow and underflow SHALL never both be 1.

Reset
REQ-027 On rst at a clock edge, out_valid, overflow, underflow, exp_out, exc_count, sticky_ovf and sticky_unf SHALL become 0.
REQ-028 During rst, in_ready SHALL read 1, and transfers in that cycle SHALL be discarded.
REQ-029 rst asserted mid-stall SHALL drop the held result, with no delivery after reset releases.

Configuration
REQ-030 With macro EXP_MON_STICKY_EN defined, sticky_ovf and sticky_unf SHALL exist and follow next = (clr ? 0 : current) | (transfer && flag), so a set wins over a simultaneous clr.
REQ-031 Without EXP_MON_STICKY_EN, the ports sticky_ovf and sticky_unf and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 EW=9: transfer in_exp=0x0FE, then 0x0FF, then 0x000, with out_ready=1 -> results (ovf,unf) = (0,0), (1,0), (0,1) on consecutive cycles; exc_count=2.
REQ-033 EW=12: in_exp=0x7FF -> overflow=1; in_exp=0x001 -> no flags; in_exp=0x000 -> underflow=1.
REQ-034 Hold out_ready=0 for 3 cycles after transfer of 0x1FF -> in_ready=0, outputs stable with overflow=1; out_ready=1 -> next input accepted with no bubble.
REQ-035 CW=2: five overflowing transfers -> exc_count reads 1, 2, 3, 3, 3; clr together with a sixth overflow -> 1.
REQ-036 EXP_MON_STICKY_EN defined: overflow transfer, then clr together with an underflow transfer -> sticky_ovf=0, sticky_unf=1; rst during a stall -> all outputs 0 and out_valid stays 0 after release.

Source files
------------

// File: rtl/exp_range_monitor.sv
// Purpose : registers a rounded exponent and flags it as overflow (> U_LIMIT) or
//           underflow (< L_LIMIT); counts flagged results in a saturating counter.
// Latency : 1 cycle from transfer to out_valid/exp_out/overflow/underflow.
// Backpressure: in_ready = !out_valid || out_ready, so the output stage holds while
//           downstream stalls and streams one result per cycle otherwise.
//
// Optional feature macro: EXP_MON_STICKY_EN adds sticky_ovf/sticky_unf ports.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input handshake; in_exp is the EW-bit exponent
//   out_valid/out_ready - output handshake; exp_out, overflow, underflow held result
//   clr               - synchronous clear of exc_count (and sticky flags)
//   exc_count         - saturating count of accepted flagged results
//   sticky_ovf/unf    - accumulated flags (only with EXP_MON_STICKY_EN)
module exp_range_monitor #(
  parameter int          EW      = 9,
  parameter int unsigned U_LIMIT = 2 ** (EW - 1) - 2,
  parameter int unsigned L_LIMIT = 1,
  parameter int          CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overflow,
  output logic          underflow,
  output logic [EW-1:0] exp_out,
  input  logic          clr,
  output logic [CW-1:0] exc_count
`ifdef EXP_MON_STICKY_EN
  ,
  output logic          sticky_ovf,
  output logic          sticky_unf
`endif
);

  localparam logic [EW-1:0] U_LIM   = U_LIMIT[EW-1:0];
  localparam logic [EW-1:0] L_LIM   = L_LIMIT[EW-1:0];
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_base;
  logic          xfer;
  logic          ovf_in;
  logic          unf_in;

  // Reset forces in_ready high so upstream never sees a stall during reset;
  // anything it offers in that cycle is dropped via the !rst term in xfer.
  assign in_ready = rst | ~vld_q | out_ready;
  assign xfer     = in_valid & in_ready & ~rst;
  assign ovf_in   = (in_exp > U_LIM);
  assign unf_in   = (in_exp < L_LIM);

  always_comb begin
    vld_d = vld_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    exp_d = exp_q;
    if (xfer) begin
      vld_d = 1'b1;
      ovf_d = ovf_in;
      unf_d = unf_in;
      exp_d = in_exp;
    end else if (out_ready) begin
      // Result consumed with nothing behind it: drop valid and the flags with it.
      vld_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // clr is applied first so a counted transfer in the same cycle lands on 1.
  always_comb begin
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (xfer && (ovf_in || unf_in) && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      exp_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign exp_out   = exp_q;
  // Gated by valid so the flags can never be seen without a result.
  assign overflow  = ovf_q & vld_q;
  assign underflow = unf_q & vld_q;
  assign exc_count = cnt_q;

`ifdef EXP_MON_STICKY_EN
  logic sovf_q, sovf_d;
  logic sunf_q, sunf_d;

  // A flag set in the clearing cycle survives the clear.
  always_comb begin
    sovf_d = (clr ? 1'b0 : sovf_q) | (xfer & ovf_in);
    sunf_d = (clr ? 1'b0 : sunf_q) | (xfer & unf_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sovf_q <= 1'b0;
      sunf_q <= 1'b0;
    end else begin
      sovf_q <= sovf_d;
      sunf_q <= sunf_d;
    end
  end

  assign sticky_ovf = sovf_q;
  assign sticky_unf = sunf_q;
`endif

endmodule

// File: tb/tb_exp_range_monitor.sv
module tb_exp_range_monitor;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [8:0]  in_exp9;
  logic [11:0] in_exp12;

  // Main instance: EW=9, CW=8
  logic        in_ready, out_valid, overflow, underflow;
  logic [8:0]  exp_out;
  logic [7:0]  exc_count;
`ifdef EXP_MON_STICKY_EN
  logic        sticky_ovf, sticky_unf;
`endif

  // EW=12 instance
  logic        d12_in_ready, d12_out_valid, d12_ovf, d12_unf;
  logic [11:0] d12_exp_out;
  logic [7:0]  d12_cnt;
`ifdef EXP_MON_STICKY_EN
  logic        d12_sovf, d12_sunf;
`endif

  // CW=2 instance
  logic        c2_in_ready, c2_out_valid, c2_ovf, c2_unf;
  logic [8:0]  c2_exp_out;
  logic [1:0]  c2_cnt;
`ifdef EXP_MON_STICKY_EN
  logic        c2_sovf, c2_sunf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exp_range_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp9),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .underflow(underflow), .exp_out(exp_out), .clr(clr), .exc_count(exc_count)
`ifdef EXP_MON_STICKY_EN
    , .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
`endif
  );

  exp_range_monitor #(.EW(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d12_in_ready), .in_exp(in_exp12),
    .out_valid(d12_out_valid), .out_ready(out_ready), .overflow(d12_ovf),
    .underflow(d12_unf), .exp_out(d12_exp_out), .clr(clr), .exc_count(d12_cnt)
`ifdef EXP_MON_STICKY_EN
    , .sticky_ovf(d12_sovf), .sticky_unf(d12_sunf)
`endif
  );

  exp_range_monitor #(.CW(2)) dutc2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready), .in_exp(in_exp9),
    .out_valid(c2_out_valid), .out_ready(out_ready), .overflow(c2_ovf),
    .underflow(c2_unf), .exp_out(c2_exp_out), .clr(clr), .exc_count(c2_cnt)
`ifdef EXP_MON_STICKY_EN
    , .sticky_ovf(c2_sovf), .sticky_unf(c2_sunf)
`endif
  );

  // Reference model of the main instance (EW=9: normal range 1..254, CW=8)
  int m_vld, m_exp, m_ovf, m_unf, m_cnt, m_sovf, m_sunf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_exp = 0; m_ovf = 0; m_unf = 0; m_cnt = 0; m_sovf = 0; m_sunf = 0;
  endtask

  // Compare main DUT against the model, then advance one clock and the model with it.
  task automatic cycle();
    int rdy, xf, fo, fu, e, c;
    #1;
    rdy = (rst || !m_vld || out_ready) ? 1 : 0;
    chk("out_valid", {31'b0, out_valid}, m_vld);
    chk("in_ready", {31'b0, in_ready}, rdy);
    if (m_vld != 0) chk("exp_out", {23'b0, exp_out}, m_exp);
    chk("overflow", {31'b0, overflow}, m_ovf);
    chk("underflow", {31'b0, underflow}, m_unf);
    chk("exc_count", {24'b0, exc_count}, m_cnt);
`ifdef EXP_MON_STICKY_EN
    chk("sticky_ovf", {31'b0, sticky_ovf}, m_sovf);
    chk("sticky_unf", {31'b0, sticky_unf}, m_sunf);
`endif
    e  = int'(in_exp9);
    xf = (in_valid && rdy && !rst) ? 1 : 0;
    fo = (e > 254) ? 1 : 0;
    fu = (e < 1) ? 1 : 0;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      c = clr ? 0 : m_cnt;
      if (xf && (fo || fu)) c = (c == 255) ? 255 : c + 1;
      m_cnt  = c;
      m_sovf = ((clr ? 0 : m_sovf) | (xf & fo));
      m_sunf = ((clr ? 0 : m_sunf) | (xf & fu));
      if (xf) begin
        m_vld = 1; m_exp = e; m_ovf = fo; m_unf = fu;
      end else if (out_ready) begin
        m_vld = 0; m_ovf = 0; m_unf = 0;
      end
    end
  endtask

  initial begin
    int c2_exp_seq[5] = '{1, 2, 3, 3, 3};
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_exp9 = '0; in_exp12 = '0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_c2_cnt", {30'b0, c2_cnt}, 0);
    chk("rst_d12_valid", {31'b0, d12_out_valid}, 0);
    cycle();
    rst = 1'b0;
    cycle();

    // Boundary sequence, EW=9 and EW=12 side by side
    in_valid = 1'b1; out_ready = 1'b1;
    in_exp9 = 9'h0FE; in_exp12 = 12'h7FF; cycle();
    chk("seq_fe_ovf", {31'b0, overflow}, 0);
    chk("seq_fe_unf", {31'b0, underflow}, 0);
    chk("d12_7ff_ovf", {31'b0, d12_ovf}, 1);
    in_exp9 = 9'h0FF; in_exp12 = 12'h001; cycle();
    chk("seq_ff_ovf", {31'b0, overflow}, 1);
    chk("d12_001_flags", {30'b0, d12_ovf, d12_unf}, 0);
    in_exp9 = 9'h000; in_exp12 = 12'h000; cycle();
    chk("seq_00_unf", {31'b0, underflow}, 1);
    chk("seq_00_ovf", {31'b0, overflow}, 0);
    chk("seq_cnt", {24'b0, exc_count}, 2);
    chk("d12_000_unf", {31'b0, d12_unf}, 1);

    // Stall with overflowing result held
    in_exp9 = 9'h1FF; cycle();
    out_ready = 1'b0; in_exp9 = 9'h055;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rdy", {31'b0, in_ready}, 0);
      chk("stall_exp", {23'b0, exp_out}, 9'h1FF);
      chk("stall_ovf", {31'b0, overflow}, 1);
    end
    out_ready = 1'b1; cycle();
    chk("unstall_vld", {31'b0, out_valid}, 1);
    chk("unstall_exp", {23'b0, exp_out}, 9'h055);

    // Saturation on a 2-bit counter
    in_valid = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0; in_valid = 1'b1; in_exp9 = 9'h1FF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("c2_sat", {30'b0, c2_cnt}, c2_exp_seq[i]);
    end
    clr = 1'b1; cycle();
    chk("c2_clr_inc", {30'b0, c2_cnt}, 1);
    clr = 1'b0; in_exp9 = 9'h080; cycle();
    clr = 1'b1; in_valid = 1'b0; cycle();
    chk("clr_alone", {24'b0, exc_count}, 0);
    clr = 1'b0;

`ifdef EXP_MON_STICKY_EN
    in_valid = 1'b1; in_exp9 = 9'h100; cycle();
    clr = 1'b1; in_exp9 = 9'h000; cycle();
    chk("sticky_ovf_clr", {31'b0, sticky_ovf}, 0);
    chk("sticky_unf_set", {31'b0, sticky_unf}, 1);
    clr = 1'b0;
`endif

    // Reset in the middle of a stall drops the held result
    in_valid = 1'b1; in_exp9 = 9'h1FF; out_ready = 1'b1; cycle();
    in_valid = 1'b0; out_ready = 1'b0; cycle();
    rst = 1'b1; in_valid = 1'b1; cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cycle();
    cycle();
    chk("rst_stall_vld", {31'b0, out_valid}, 0);
    chk("rst_stall_ovf", {31'b0, overflow}, 0);
    chk("rst_stall_cnt", {24'b0, exc_count}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 7);
      case (r)
        0: in_exp9 = 9'd0;
        1: in_exp9 = 9'd1;
        2: in_exp9 = 9'd254;
        3: in_exp9 = 9'd255;
        4: in_exp9 = 9'd511;
        default: in_exp9 = 9'($urandom_range(0, 511));
      endcase
      cycle();
    end
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
